toll_lane_ctrl: RTL and testbench
=================================

# toll_lane_ctrl

Parametrised single-lane toll-gate controller: the successor to the fixed-width gate controller. It tracks vehicles between the entry (sensor1), reader (sensor2) and exit (sensor3) loops and measures entry-to-reader transit time. It arbitrates the E-pass verdict with a configurable timeout and drives barrier up/down pulses plus status to the fee calculator and the barrier actuator. It sits between the synchronised sensor front-end and the barrier/fee datapath.

## Interface
- `CNT_W`, 4: occupancy counter width.
- `TIME_W`, 16: transit timer width.
- `EPASS_TO`, 1000: cycles allowed in CALC before the verdict times out (≥1, < 2^TIME_W).

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sensor1`  in  1  entry loop, high while a vehicle is present (already synchronous to `clk`).
- `sensor2`  in  1  reader loop, level.
- `sensor3`  in  1  exit loop, level.
- `valid_epass`  in  2  E-pass verdict: 10 valid, 01 invalid, 00/11 pending.
- `init`  out  1  high while in IDLE.
- `count`  out  1  high while in TIMING.
- `cal`  out  1  high while in CALC.
- `up`  out  1  one-cycle barrier-raise pulse.
- `down`  out  1  one-cycle barrier-lower pulse.
- `reject`  out  1  one-cycle reject pulse (invalid verdict or timeout).
- `fault`  out  1  one-cycle fault pulse.
- `time_valid`  out  1  one-cycle strobe: `transit_time` updated.
- `transit_time`  out  TIME_W  last measured transit, in cycles.
- `occupancy`  out  CNT_W  vehicles between entry and exit.

## Operation
- Edge detect: each sensor is registered once (`sN_q`, reset 0). rise = s & ~s_q, fall = ~s & s_q, both evaluated combinationally in the current cycle.
- Occupancy, updated in every state:
  - +1 on sensor1 rise; −1 on sensor3 fall; both in the same cycle leaves it unchanged.
  - Increment at 2^CNT_W−1 holds the value and pulses `fault`. Decrement at 0 holds the value and pulses `fault`.
- FSM (Moore decodes `init`/`count`/`cal` from the state register):
  - IDLE: on sensor1 rise → TIMING, timer := 0.
  - TIMING: timer +1 per cycle.
    - On sensor2 rise → CALC; `transit_time` := timer+1; `time_valid` pulses; wait counter := 0.
    - If timer reaches 2^TIME_W−1 with no sensor2 rise → IDLE, `fault` pulses.
  - CALC: wait counter +1 per cycle.
    - verdict 10 → `up` pulses, → PASS.
    - verdict 01 → `reject` pulses, → IDLE.
    - 00/11 → stay in CALC. When wait counter reaches EPASS_TO−1 while still pending → `reject` and `fault` pulse, → IDLE.
  - PASS: on sensor3 fall → IDLE. A sensor1 rise in PASS updates occupancy only; it does not start a new measurement.
- `down` pulses on any sensor3 fall whose resulting occupancy is 0, in any state.
- PASS and IDLE share no outputs. The encoding has 4 states; no illegal state is reachable, but the default case → IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, so `init`=1. All other outputs, counters, `transit_time` and edge registers are 0.
- State changes one clock after the qualifying input cycle: an event seen in cycle n takes effect in the new state from cycle n+1.
- `up`, `down`, `reject`, `fault`, `time_valid` are registered and high exactly in cycle n+1 for an event in cycle n. `transit_time` is valid in the same cycle as `time_valid` and holds until the next measurement.
- `occupancy` reflects the events of cycle n from cycle n+1.
- Sensor levels held high produce no further edges. Reset mid-operation aborts any measurement; a verdict pending at reset is discarded.
- `valid_epass` is sampled only in CALC; it is ignored in all other states.

## Test plan
- Reset: hold `reset_n`=0 → `init`=1, all other outputs 0, `occupancy`=0.
- Nominal pass: sensor1 rises in cycle 0, sensor2 in cycle 5, then `valid_epass`=10 → `time_valid`=1 and `transit_time`=5 in cycle 6; `up`=1 one cycle later. A subsequent sensor3 fall → `down`=1, `occupancy`=0, state IDLE.
- Invalid pass: same entry, verdict 01 → `reject` one cycle, `up` never asserted, returns to IDLE. `occupancy` stays 1 until sensor3 falls, at which point `down` pulses.
- Verdict timeout (EPASS_TO=4, verdict held 00) → `reject` and `fault` high in the same cycle, 4 cycles after entering CALC, then IDLE.
- Occupancy boundaries (CNT_W=2):
  - 3 entries, then a 4th → holds at 3, `fault` pulses.
  - Simultaneous sensor1 rise and sensor3 fall → occupancy unchanged.
  - sensor3 fall at 0 → `fault`, no `down`.
- Transit saturation (TIME_W=4): sensor1 rises, sensor2 held low → `fault` after 15 TIMING cycles, state IDLE, `time_valid` never asserted.

Source files
------------

// File: rtl/toll_lane_ctrl.sv
// toll_lane_ctrl - single-lane toll-gate controller.
//
// Tracks vehicles between the entry (sensor1), reader (sensor2) and exit
// (sensor3) loops, times entry-to-reader transit, arbitrates the E-pass
// verdict with a timeout and pulses barrier up/down.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   sensor1/2/3           entry / reader / exit loop levels (synchronous)
//   valid_epass[1:0]      verdict: 10 valid, 01 invalid, 00/11 pending
//   init/count/cal        state decodes: IDLE / TIMING / CALC
//   up, down              one-cycle barrier raise / lower pulses
//   reject, fault         one-cycle reject / fault pulses
//   time_valid            one-cycle strobe, transit_time just updated
//   transit_time[TIME_W]  last measured entry-to-reader transit, cycles
//   occupancy[CNT_W]      vehicles between entry and exit loops
module toll_lane_ctrl #(
  parameter int CNT_W    = 4,
  parameter int TIME_W   = 16,
  parameter int EPASS_TO = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sensor1,
  input  logic              sensor2,
  input  logic              sensor3,
  input  logic [1:0]        valid_epass,
  output logic              init,
  output logic              count,
  output logic              cal,
  output logic              up,
  output logic              down,
  output logic              reject,
  output logic              fault,
  output logic              time_valid,
  output logic [TIME_W-1:0] transit_time,
  output logic [CNT_W-1:0]  occupancy
);

  typedef enum logic [1:0] {S_IDLE, S_TIMING, S_CALC, S_PASS} state_t;

  localparam logic [TIME_W-1:0] LP_TO_LAST = TIME_W'(EPASS_TO - 1);

  state_t              r_state;
  logic                r_s1_q, r_s2_q, r_s3_q;
  logic [TIME_W-1:0]   r_timer, r_wait, r_transit;
  logic [CNT_W-1:0]    r_occ;
  logic                r_up, r_down, r_reject, r_fault, r_tv;

  logic                w_s1_rise, w_s2_rise, w_s3_fall;
  logic                w_inc, w_dec, w_ovf, w_unf;
  logic [CNT_W-1:0]    w_occ_nxt;
  logic                w_down;

  assign w_s1_rise = sensor1 & ~r_s1_q;
  assign w_s2_rise = sensor2 & ~r_s2_q;
  assign w_s3_fall = ~sensor3 & r_s3_q;

  // Entry and exit in the same cycle cancel out and raise no fault.
  assign w_inc = w_s1_rise & ~w_s3_fall;
  assign w_dec = w_s3_fall & ~w_s1_rise;
  assign w_ovf = w_inc & (r_occ == '1);
  assign w_unf = w_dec & (r_occ == '0);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_inc && !w_ovf)      w_occ_nxt = r_occ + 1'b1;
    else if (w_dec && !w_unf) w_occ_nxt = r_occ - 1'b1;
  end

  // An exit seen with the lane already empty is a fault, not a lane-clear.
  assign w_down = w_s3_fall & ~w_unf & (w_occ_nxt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_q <= 1'b0;
      r_s2_q <= 1'b0;
      r_s3_q <= 1'b0;
      r_occ  <= '0;
      r_down <= 1'b0;
    end else begin
      r_s1_q <= sensor1;
      r_s2_q <= sensor2;
      r_s3_q <= sensor3;
      r_occ  <= w_occ_nxt;
      r_down <= w_down;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_wait    <= '0;
      r_transit <= '0;
      r_up      <= 1'b0;
      r_reject  <= 1'b0;
      r_fault   <= 1'b0;
      r_tv      <= 1'b0;
    end else begin
      r_up     <= 1'b0;
      r_reject <= 1'b0;
      r_tv     <= 1'b0;
      r_fault  <= w_ovf | w_unf;
      case (r_state)
        S_IDLE: begin
          if (w_s1_rise) begin
            r_state <= S_TIMING;
            r_timer <= '0;
          end
        end
        S_TIMING: begin
          if (w_s2_rise) begin
            r_state   <= S_CALC;
            // Saturate so a reader hit on the very last tick cannot wrap.
            r_transit <= (r_timer == '1) ? r_timer : r_timer + 1'b1;
            r_tv      <= 1'b1;
            r_wait    <= '0;
          end else if (r_timer == '1) begin
            r_state <= S_IDLE;
            r_fault <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_CALC: begin
          r_wait <= r_wait + 1'b1;
          if (valid_epass == 2'b10) begin
            r_up    <= 1'b1;
            r_state <= S_PASS;
          end else if (valid_epass == 2'b01) begin
            r_reject <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_wait == LP_TO_LAST) begin
            r_reject <= 1'b1;
            r_fault  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_PASS: begin
          if (w_s3_fall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign init         = (r_state == S_IDLE);
  assign count        = (r_state == S_TIMING);
  assign cal          = (r_state == S_CALC);
  assign up           = r_up;
  assign down         = r_down;
  assign reject       = r_reject;
  assign fault        = r_fault;
  assign time_valid   = r_tv;
  assign transit_time = r_transit;
  assign occupancy    = r_occ;

endmodule

// File: tb/tb_toll_lane_ctrl.sv
// Directed bench for toll_lane_ctrl (CNT_W=2, TIME_W=4, EPASS_TO=4).
// Inputs change 1 time unit after a rising edge; each tick() advances one
// cycle and leaves outputs stable for sampling.
module tb_toll_lane_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor1 = 1'b0, sensor2 = 1'b0, sensor3 = 1'b0;
  logic [1:0] valid_epass = 2'b00;
  logic       init, count, cal, up, down, reject, fault, time_valid;
  logic [3:0] transit_time;
  logic [1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  toll_lane_ctrl #(.CNT_W(2), .TIME_W(4), .EPASS_TO(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
    .valid_epass(valid_epass),
    .init(init), .count(count), .cal(cal), .up(up), .down(down),
    .reject(reject), .fault(fault), .time_valid(time_valid),
    .transit_time(transit_time), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b0; valid_epass = 2'b00;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  logic tv_seen, f_seen;

  initial begin
    // ---- reset state
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_init", init, 1);
    chk("rst_count", count, 0);
    chk("rst_cal", cal, 0);
    chk("rst_pulses", {up, down, reject, fault, time_valid}, 0);
    chk("rst_transit", transit_time, 0);
    chk("rst_occ", occupancy, 0);
    reset_n = 1'b1;
    tick();

    // ---- nominal pass: entry cycle 0, reader cycle 5
    sensor1 = 1'b1; tick();
    chk("nom_count", count, 1);
    chk("nom_occ1", occupancy, 1);
    repeat (4) tick();
    sensor2 = 1'b1; tick();
    chk("nom_tv", time_valid, 1);
    chk("nom_transit", transit_time, 5);
    chk("nom_cal", cal, 1);
    valid_epass = 2'b10; tick();
    chk("nom_up", up, 1);
    chk("nom_pass_state", {init, count, cal}, 3'b000);
    valid_epass = 2'b00; tick();
    chk("nom_up_once", {up, time_valid}, 0);
    chk("nom_transit_hold", transit_time, 5);
    sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b1; tick();
    sensor3 = 1'b0; tick();
    chk("nom_down", down, 1);
    chk("nom_occ0", occupancy, 0);
    chk("nom_idle", init, 1);
    tick();
    chk("nom_down_once", down, 0);

    // ---- invalid verdict (verdict 10 in IDLE must be ignored)
    sensor1 = 1'b1; valid_epass = 2'b10; tick();
    chk("inv_ignored_up", up, 0);
    valid_epass = 2'b00;
    sensor2 = 1'b1; tick();
    chk("inv_cal", cal, 1);
    valid_epass = 2'b01; tick();
    chk("inv_reject", reject, 1);
    chk("inv_no_up", up, 0);
    chk("inv_idle", init, 1);
    chk("inv_occ", occupancy, 1);
    valid_epass = 2'b00; tick();
    chk("inv_reject_once", reject, 0);
    sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b1; tick();
    sensor3 = 1'b0; tick();
    chk("inv_down", down, 1);
    chk("inv_occ0", occupancy, 0);

    // ---- verdict timeout: pending verdict, EPASS_TO=4
    sensor1 = 1'b1; tick();
    sensor2 = 1'b1; tick();
    chk("to_cal", cal, 1);
    tick(); tick(); tick();
    chk("to_not_yet", {reject, fault}, 2'b00);
    tick();
    chk("to_reject_fault", {reject, fault}, 2'b11);
    chk("to_idle", init, 1);
    sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b1; tick();
    sensor3 = 1'b0; tick();
    chk("to_down", down, 1);

    // ---- occupancy underflow from empty lane
    do_reset();
    sensor3 = 1'b1; tick();
    sensor3 = 1'b0; tick();
    chk("unf_fault", fault, 1);
    chk("unf_no_down", down, 0);
    chk("unf_occ", occupancy, 0);

    // ---- occupancy overflow: 3 entries fill, 4th holds
    for (int i = 0; i < 3; i++) begin
      sensor1 = 1'b1; tick();
      sensor1 = 1'b0; tick();
    end
    chk("ovf_occ3", occupancy, 3);
    sensor1 = 1'b1; tick();
    chk("ovf_hold", occupancy, 3);
    chk("ovf_fault", fault, 1);
    sensor1 = 1'b0; sensor3 = 1'b1; tick();
    chk("ovf_fault_once", fault, 0);
    // simultaneous entry and exit
    sensor1 = 1'b1; sensor3 = 1'b0; tick();
    chk("sim_occ", occupancy, 3);
    chk("sim_no_pulse", {down, fault}, 2'b00);
    chk("mid_count", count, 1);
    // reset mid-measurement aborts it
    reset_n = 1'b0; #1;
    chk("mid_rst_init", init, 1);
    chk("mid_rst_occ", occupancy, 0);
    do_reset();

    // ---- transit saturation, TIME_W=4
    sensor1 = 1'b1; tick();
    tv_seen = time_valid; f_seen = fault;
    for (int i = 0; i < 15; i++) begin
      tick();
      tv_seen |= time_valid; f_seen |= fault;
    end
    chk("sat_still_timing", count, 1);
    chk("sat_no_early_fault", f_seen, 0);
    tick();
    chk("sat_fault", fault, 1);
    chk("sat_idle", init, 1);
    chk("sat_no_tv", tv_seen | time_valid, 0);
    chk("sat_transit_kept", transit_time, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
